lt24_pic_compositor: RTL and testbench



---
 rtl/lt24_comp_pkg.sv | 24 ++
 rtl/lt24_pix_op.sv | 21 ++
 rtl/lt24_pic_compositor.sv | 131 +++++++++++++
 tb/tb_lt24_pic_compositor.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/lt24_comp_pkg.sv
// Shared definitions for the LT24 frame compositor: command fields, op codes,
// FSM states and the RGB332 -> RGB565 colour expansion.
package lt24_comp_pkg;

   localparam int PATTERN_W = 12;

   localparam logic [1:0] OP_COPY  = 2'b00;
   localparam logic [1:0] OP_FILL  = 2'b01;
   localparam logic [1:0] OP_XOR   = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } comp_state_t;

   // Replicate the top bits of each channel so full-scale 332 maps to full-scale 565.
   function automatic logic [15:0] rgb332_to_565(input logic [7:0] c);
      return {c[7:5], c[7:6], c[4:2], c[4:2], c[1:0], c[1:0], c[1]};
   endfunction

endpackage

// File: rtl/lt24_pix_op.sv
// Combinational pixel operator used in the write stage of the compositor.
module lt24_pix_op
   import lt24_comp_pkg::*;
(
   input  logic [1:0]  op,
   input  logic [15:0] colour565,
   input  logic [15:0] bg_readdata,
   output logic [15:0] pixel
);

   always_comb begin
      pixel = 16'h0000;
      case (op)
         OP_COPY:  pixel = bg_readdata;
         OP_FILL:  pixel = colour565;
         OP_XOR:   pixel = bg_readdata ^ colour565;
         default:  pixel = 16'h0000;
      endcase
   end

endmodule

// File: rtl/lt24_pic_compositor.sv
// Streams background_mem through a one-word-per-cycle pixel op into pic_mem,
// one pass of NUM_WORDS words per accepted start edge on pattern[11].
//
// state | meaning
// IDLE  | after reset, waiting for a start edge
// RUN   | issuing background read addresses 0..NUM_WORDS-1
// DRAIN | final pic write of the last word
// DONE  | finish_flag high, counter held, waiting for a new start edge
module lt24_pic_compositor
   import lt24_comp_pkg::*;
#(
   parameter int ADDR_W    = 13,
   parameter int DATA_W    = 16,
   parameter int NUM_WORDS = 8192
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [PATTERN_W-1:0] pattern,
   output logic                 finish_flag,
   output logic [31:0]          counter,
   output logic [ADDR_W-1:0]    bg_address,
   output logic                 bg_chipselect,
   output logic                 bg_clken,
   output logic                 bg_write,
   output logic [1:0]           bg_byteenable,
   output logic [DATA_W-1:0]    bg_writedata,
   input  logic [DATA_W-1:0]    bg_readdata,
   output logic [ADDR_W-1:0]    pic_address,
   output logic                 pic_chipselect,
   output logic                 pic_clken,
   output logic                 pic_write,
   output logic [1:0]           pic_byteenable,
   output logic [DATA_W-1:0]    pic_writedata
);

   // Truncation is exact for NUM_WORDS = 2**ADDR_W: the last address is all ones.
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

   comp_state_t       state, state_nxt;
   logic              pat_q;
   logic [1:0]        op_q;
   logic [15:0]       colour_q;
   logic [ADDR_W-1:0] rd_addr;
   logic              wr_valid;
   logic [ADDR_W-1:0] wr_addr;
   logic [15:0]       pixel;
   logic              start_acc;
   logic              last_rd;
   logic              pattern_unused;

   assign pattern_unused = pattern[8];

   assign last_rd   = (rd_addr == LAST_ADDR);
   assign start_acc = pattern[PATTERN_W-1] && !pat_q && ((state == IDLE) || (state == DONE));

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: if (start_acc) state_nxt = RUN;
         RUN:        if (last_rd) state_nxt = DRAIN;
         DRAIN:      state_nxt = DONE;
         default:    state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bg_address    = '0;
      bg_chipselect = 1'b0;
      if (state == RUN) begin
         bg_address    = rd_addr;
         bg_chipselect = (op_q == OP_COPY) || (op_q == OP_XOR);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pat_q       <= 1'b0;
         op_q        <= OP_COPY;
         colour_q    <= 16'h0000;
         rd_addr     <= '0;
         wr_valid    <= 1'b0;
         wr_addr     <= '0;
         counter     <= 32'd0;
         finish_flag <= 1'b0;
      end else begin
         pat_q    <= pattern[PATTERN_W-1];
         wr_valid <= (state == RUN);
         wr_addr  <= rd_addr;
         if (start_acc) begin
            op_q        <= pattern[10:9];
            colour_q    <= rgb332_to_565(pattern[7:0]);
            rd_addr     <= '0;
            counter     <= 32'd0;
            finish_flag <= 1'b0;
         end else begin
            if ((state == RUN) && !last_rd)
               rd_addr <= rd_addr + ADDR_W'(1);
            if (((state == RUN) || (state == DRAIN)) && (counter != 32'hFFFF_FFFF))
               counter <= counter + 32'd1;
            if (state == DRAIN)
               finish_flag <= 1'b1;
         end
      end
   end

   // bg_readdata arrives one cycle after its address, aligned with wr_valid.
   lt24_pix_op u_pix_op (
      .op          (op_q),
      .colour565   (colour_q),
      .bg_readdata (bg_readdata),
      .pixel       (pixel)
   );

   assign pic_chipselect = wr_valid;
   assign pic_write      = wr_valid;
   assign pic_address    = wr_addr;
   assign pic_writedata  = wr_valid ? pixel : '0;

   assign bg_clken       = 1'b1;
   assign bg_write       = 1'b0;
   assign bg_byteenable  = 2'b11;
   assign bg_writedata   = '0;
   assign pic_clken      = 1'b1;
   assign pic_byteenable = 2'b11;

endmodule

// File: tb/tb_lt24_pic_compositor.sv
// Bench for the LT24 compositor: three instances (8, 1 and 8192 words) with
// behavioural memories and a reference pixel model.
module tb_lt24_pic_compositor;

   logic        clk = 1'b0;
   logic        rst [3];
   logic [11:0] pattern [3];
   logic        finish_flag [3];
   logic [31:0] counter [3];
   logic [12:0] bg_address [3];
   logic        bg_chipselect [3];
   logic        bg_clken [3];
   logic        bg_write [3];
   logic [1:0]  bg_byteenable [3];
   logic [15:0] bg_writedata [3];
   logic [15:0] bg_rd [3];
   logic [12:0] pic_address [3];
   logic        pic_chipselect [3];
   logic        pic_clken [3];
   logic        pic_write [3];
   logic [1:0]  pic_byteenable [3];
   logic [15:0] pic_writedata [3];

   logic [15:0] bg_mem  [3][8192];
   logic [15:0] pic_mem [3][8192];
   logic        clr_req [3];
   int          wr_cnt [3], order_err [3], gap_err [3], zero_wr [3], last_addr [3];
   logic        cs_seen [3], prev_wr [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      lt24_pic_compositor #(
         .ADDR_W(13), .DATA_W(16), .NUM_WORDS(g == 0 ? 8 : (g == 1 ? 1 : 8192))
      ) u_dut (
         .clk(clk), .reset(rst[g]), .pattern(pattern[g]),
         .finish_flag(finish_flag[g]), .counter(counter[g]),
         .bg_address(bg_address[g]), .bg_chipselect(bg_chipselect[g]),
         .bg_clken(bg_clken[g]), .bg_write(bg_write[g]),
         .bg_byteenable(bg_byteenable[g]), .bg_writedata(bg_writedata[g]),
         .bg_readdata(bg_rd[g]),
         .pic_address(pic_address[g]), .pic_chipselect(pic_chipselect[g]),
         .pic_clken(pic_clken[g]), .pic_write(pic_write[g]),
         .pic_byteenable(pic_byteenable[g]), .pic_writedata(pic_writedata[g])
      );
   end

   // Memory models plus write-stream bookkeeping (count, order, gaps, address 0 hits).
   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         bg_rd[k] <= bg_chipselect[k] ? bg_mem[k][bg_address[k]] : 16'($urandom);
         if (clr_req[k]) begin
            for (int i = 0; i < 8192; i++) pic_mem[k][i] <= 16'hDEAD;
            wr_cnt[k] <= 0; order_err[k] <= 0; gap_err[k] <= 0;
            zero_wr[k] <= 0; last_addr[k] <= -1; cs_seen[k] <= 1'b0; prev_wr[k] <= 1'b0;
         end else begin
            prev_wr[k] <= pic_chipselect[k] && pic_write[k];
            if (bg_chipselect[k]) cs_seen[k] <= 1'b1;
            if (pic_chipselect[k] && pic_write[k]) begin
               pic_mem[k][pic_address[k]] <= pic_writedata[k];
               wr_cnt[k] <= wr_cnt[k] + 1;
               if (int'(pic_address[k]) != wr_cnt[k]) order_err[k] <= order_err[k] + 1;
               if (wr_cnt[k] > 0 && !prev_wr[k]) gap_err[k] <= gap_err[k] + 1;
               if (pic_address[k] == 13'd0) zero_wr[k] <= zero_wr[k] + 1;
               last_addr[k] <= int'(pic_address[k]);
            end
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic int nw(input int k);
      return (k == 0) ? 8 : ((k == 1) ? 1 : 8192);
   endfunction

   // Reference pixel: channel expansion by arithmetic bit replication.
   function automatic logic [15:0] exp_px(input logic [1:0] op, input logic [7:0] c,
                                          input logic [15:0] bg);
      int r3, g3, b2, col;
      r3  = int'(c) / 32;
      g3  = (int'(c) / 4) % 8;
      b2  = int'(c) % 4;
      col = ((r3 * 4 + r3 / 2) * 2048) + ((g3 * 8 + g3) * 32) + (b2 * 8 + b2 * 2 + b2 / 2);
      case (op)
         2'd0:    return bg;
         2'd1:    return 16'(col);
         2'd2:    return bg ^ 16'(col);
         default: return 16'h0000;
      endcase
   endfunction

   task automatic load_bg(input int k, input int bg_kind);
      for (int i = 0; i < nw(k); i++)
         bg_mem[k][i] = (bg_kind == 1) ? 16'(32'h1000 + i) :
                        (bg_kind == 2) ? 16'hFFFF : 16'($urandom);
      @(negedge clk); clr_req[k] = 1'b1;
      @(negedge clk); clr_req[k] = 1'b0;
   endtask

   task automatic run_cmd(input int k, input logic [1:0] op, input logic [7:0] col,
                          input int bg_kind, input bit retrig);
      int n, cyc;
      logic [15:0] e;
      n = nw(k);
      load_bg(k, bg_kind);
      pattern[k] = {1'b1, op, 1'($urandom), col};
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            check_eq("start_finish_clr", 32'(finish_flag[k]), 32'd0);
            check_eq("start_counter_clr", counter[k], 32'd0);
         end
         if (retrig && cyc >= 2 && cyc <= 5)
            pattern[k][11] = ~pattern[k][11];
         else if (!retrig && cyc == 2)
            pattern[k][10:0] = 11'($urandom);
      end while (!finish_flag[k] && cyc < n + 20);
      check_eq($sformatf("latency_%0d", k), 32'(cyc), 32'(n + 2));
      check_eq($sformatf("counter_%0d", k), counter[k], 32'(n + 1));
      check_eq($sformatf("writes_%0d", k), 32'(wr_cnt[k]), 32'(n));
      check_eq("order", 32'(order_err[k]), 32'd0);
      check_eq("gaps", 32'(gap_err[k]), 32'd0);
      check_eq("last_addr", 32'(last_addr[k]), 32'(n - 1));
      check_eq("addr0_writes", 32'(zero_wr[k]), 32'd1);
      check_eq("bg_cs_use", 32'(cs_seen[k]), 32'((op == 2'd0) || (op == 2'd2)));
      for (int i = 0; i < n; i++) begin
         e = exp_px(op, col, bg_mem[k][i]);
         if (pic_mem[k][i] !== e || i == n - 1) begin
            check_eq($sformatf("pix_%0d_%0d", k, i), 32'(pic_mem[k][i]), 32'(e));
            break;
         end
      end
      repeat (3) @(negedge clk);
      check_eq("no_extra_writes", 32'(wr_cnt[k]), 32'(n));
      check_eq("done_hold", 32'(finish_flag[k]), 32'd1);
      pattern[k] = 12'h000;
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input int k, input string tag);
      check_eq({tag, "_finish"}, 32'(finish_flag[k]), 32'd0);
      check_eq({tag, "_counter"}, counter[k], 32'd0);
      check_eq({tag, "_strobes"},
               32'({bg_chipselect[k], pic_chipselect[k], pic_write[k]}), 32'd0);
      check_eq({tag, "_addr"}, 32'({bg_address[k], pic_address[k]}), 32'd0);
      check_eq({tag, "_wdata"}, 32'(pic_writedata[k]), 32'd0);
   endtask

   initial begin
      int cyc;
      for (int k = 0; k < 3; k++) begin
         rst[k] = 1'b1; pattern[k] = 12'h000; clr_req[k] = 1'b0;
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check_reset_outputs(k, "por");
         check_eq("tied", 32'({bg_clken[k], bg_write[k], bg_byteenable[k], bg_writedata[k],
                               pic_clken[k], pic_byteenable[k]}),
                  32'({1'b1, 1'b0, 2'b11, 16'h0000, 1'b1, 2'b11}));
      end
      for (int k = 0; k < 3; k++) rst[k] = 1'b0;
      @(negedge clk);

      run_cmd(0, 2'd0, 8'h00, 1, 1'b0);
      run_cmd(0, 2'd1, 8'hE0, 0, 1'b0);
      run_cmd(0, 2'd1, 8'hFF, 0, 1'b0);
      run_cmd(0, 2'd2, 8'h1C, 2, 1'b0);
      run_cmd(0, 2'd3, 8'h00, 0, 1'b0);
      run_cmd(0, 2'd0, 8'($urandom), 0, 1'b1);

      // Reset while address 3 is on the background port.
      load_bg(0, 1);
      pattern[0] = 12'h800;
      cyc = 0;
      while (!(bg_chipselect[0] && bg_address[0] == 13'd3) && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check_eq("rst_reach_word3", 32'(bg_address[0]), 32'd3);
      rst[0] = 1'b1;
      pattern[0] = 12'h000;
      @(negedge clk);
      check_reset_outputs(0, "midrst");
      @(negedge clk);
      rst[0] = 1'b0;
      repeat (4) @(negedge clk);
      check_eq("post_rst_idle", 32'(pic_write[0]), 32'd0);
      for (int i = 4; i < 8; i++)
         check_eq($sformatf("untouched_%0d", i), 32'(pic_mem[0][i]), 32'hDEAD);

      for (int r = 0; r < 6; r++)
         run_cmd(0, 2'($urandom), 8'($urandom), 0, 1'b0);

      run_cmd(1, 2'd0, 8'h00, 0, 1'b0);
      run_cmd(1, 2'd2, 8'($urandom), 0, 1'b0);
      run_cmd(2, 2'd0, 8'h00, 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
